// File: rtl/rv32i_types.sv
// Shared RV32 type definitions used across the execution units.
// Holds the M-extension funct3 encoding consumed by the multiplier.
// No logic; types only.
package rv32i_types;

  // M-extension funct3 field. Divide/remainder encodings are carried so the
  // type covers every 3-bit value; the multiplier treats them as mulhu.
  typedef enum logic [2:0] {
    MEX_MUL    = 3'b000,
    MEX_MULH   = 3'b001,
    MEX_MULHSU = 3'b010,
    MEX_MULHU  = 3'b011,
    MEX_DIV    = 3'b100,
    MEX_DIVU   = 3'b101,
    MEX_REM    = 3'b110,
    MEX_REMU   = 3'b111
  } mex_funct3_t;

endpackage

// File: rtl/us_multiplier.sv
// Unsigned 32x32 shift-add multiply core; one multiplier bit per cycle.
// Latency: 32 run cycles after load; last_o flags the final iteration.
// Ports: clk, rst (async active-low), load_i/a_i/b_i load operands,
//        run_i advances one iteration, product_o holds the 64-bit product.
module us_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        run_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        last_o,
  output logic [63:0] product_o
);

  localparam int unsigned ITERS    = 32;
  localparam logic [4:0]  LAST_CNT = 5'(ITERS - 1);

  logic [63:0] product_q, product_d;
  logic [31:0] mcand_q, mcand_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] sum;

  // The low half of product_q starts as the multiplier and shifts out one bit
  // per cycle while the partial sum fills in from the top; after 32 shifts the
  // register holds the full product.
  always_comb begin
    sum       = {1'b0, product_q[63:32]} + (product_q[0] ? {1'b0, mcand_q} : 33'd0);
    product_d = product_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      product_d = {32'h0, b_i};
      mcand_d   = a_i;
      cnt_d     = 5'd0;
    end else if (run_i) begin
      product_d = {sum, product_q[31:1]};
      cnt_d     = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product_q <= 64'h0;
      mcand_q   <= 32'h0;
      cnt_q     <= 5'd0;
    end else begin
      product_q <= product_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
    end
  end

  assign last_o    = run_i && (cnt_q == LAST_CNT);
  assign product_o = product_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential RV32M multiplier: mul, mulh, mulhsu, mulhu over a shift-add core.
// Latency: start accepted in IDLE; 32 MUL cycles then one DONE cycle with fin.
// Ports: clk, rst (async active-low), op/start/multiplicand/multiplier in;
//        busy (MUL or DONE), fin (one-cycle strobe), result (selected half).
module seq_multiplier
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mex_funct3_t op,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        fin,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        hi_sel_q, hi_sel_d;  // 1: upper product half
  logic        neg_q, neg_d;        // operand signs differ
  logic        a_signed, b_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        accept;
  logic        core_last;
  logic [63:0] core_prod;
  logic [63:0] prod_signed;

  // Any funct3 outside the multiply group falls through to unsigned (mulhu).
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      MEX_MUL, MEX_MULH: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      MEX_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_neg  = a_signed & multiplicand[31];
  assign b_neg  = b_signed & multiplier[31];
  assign a_mag  = a_neg ? (~multiplicand + 32'd1) : multiplicand;
  assign b_mag  = b_neg ? (~multiplier + 32'd1) : multiplier;
  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d  = state_q;
    hi_sel_d = hi_sel_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_MUL;
          hi_sel_d = (op != MEX_MUL);
          neg_d    = a_neg ^ b_neg;
        end
      end
      S_MUL:   if (core_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      hi_sel_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_sel_q <= hi_sel_d;
      neg_q    <= neg_d;
    end
  end

  us_multiplier u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .run_i     (state_q == S_MUL),
    .a_i       (a_mag),
    .b_i       (b_mag),
    .last_o    (core_last),
    .product_o (core_prod)
  );

  // The core product is frozen outside MUL until the next load, so the
  // selected half stays stable from DONE until the next accepted start.
  assign prod_signed = neg_q ? (~core_prod + 64'd1) : core_prod;
  assign result      = hi_sel_q ? prod_signed[63:32] : prod_signed[31:0];
  assign busy        = (state_q == S_MUL) || (state_q == S_DONE);
  assign fin         = (state_q == S_DONE);

endmodule
